data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 35 +++
 rtl/load_align.sv | 35 +++
 rtl/data_mem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states,
// load-result source select and the default LED register address.
package data_mem_pkg;

    localparam logic [2:0]  MaskByte       = 3'b001;
    localparam logic [2:0]  MaskHalf       = 3'b011;
    localparam logic [2:0]  MaskWord       = 3'b111;
    localparam logic [31:0] LedAddrDefault = 32'h0000_2000;

    typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} access_size_e;

    typedef enum logic {StClear, StRun} state_e;

    // Where the captured load result comes from in the cycle after capture.
    typedef enum logic [1:0] {SrcZero, SrcRam, SrcLed} load_src_e;

    // Unknown size patterns fall back to a full word.
    function automatic access_size_e decode_size(input logic [2:0] size_bits);
        case (size_bits)
            MaskByte: return SizeByte;
            MaskHalf: return SizeHalf;
            MaskWord: return SizeWord;
            default:  return SizeWord;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_e size, input logic [1:0] offset);
        case (size)
            SizeByte: return 1'b0;
            SizeHalf: return offset[0];
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a RAM word and zero/sign-extends it.
module load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [3:0]  sign_mask,
    output logic [31:0] value
);

    access_size_e size;
    logic [7:0]   lane_b;
    logic [15:0]  lane_h;
    logic         sext;

    // Lane extraction and extension.
    always_comb begin
        size   = decode_size(sign_mask[2:0]);
        sext   = sign_mask[3];
        lane_b = word[7:0];
        unique case (offset)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SizeByte: value = {{24{sext & lane_b[7]}}, lane_b};
            SizeHalf: value = {{16{sext & lane_h[15]}}, lane_h};
            default:  value = word;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory for a small CPU: byte-enabled single-port RAM cleared after
// reset, a memory-mapped LED register, latency-1 loads and a sticky
// misalignment flag.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = LedAddrDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        init_done,
    output logic        misaligned,
    output logic [7:0]  led
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [IdxW-1:0]  clr_cnt_q, clr_cnt_d;
    logic             init_done_q;
    logic             misaligned_q, misaligned_d;
    logic [7:0]       led_q, led_d;

    load_src_e        ld_src_q, ld_src_d;
    logic [1:0]       ld_off_q, ld_off_d;
    logic [3:0]       ld_mask_q, ld_mask_d;
    logic [7:0]       led_cap_q, led_cap_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      ram_rdata_q;
    logic             ram_we, ram_re;
    logic [3:0]       ram_be;
    logic [IdxW-1:0]  ram_idx;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_load_val;

    access_size_e     size;
    logic             run, req_mis, hit_led, hit_ram, cpu_wr, cpu_rd;
    logic [3:0]       store_be;
    logic [31:0]      store_data;

    // Clear sequencer: walks every word once, then hands the RAM to the CPU.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == IdxW'(DEPTH_WORDS - 1)) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
    end

    // Request decode, RAM port muxing and next-state of the CPU-visible registers.
    always_comb begin
        run     = state_q == StRun;
        size    = decode_size(sign_mask[2:0]);
        req_mis = is_misaligned(size, addr[1:0]);
        hit_led = addr == LED_ADDR;
        // LED wins if it were ever placed inside the RAM window.
        hit_ram = ((addr >> (IdxW + 2)) == 32'd0) && !hit_led;
        // A simultaneous read+write is a store only.
        cpu_wr  = run && memwrite && !req_mis;
        cpu_rd  = run && memread && !memwrite;

        case (size)
            SizeByte: begin
                store_be   = 4'b0001 << addr[1:0];
                store_data = {4{write_data[7:0]}};
            end
            SizeHalf: begin
                store_be   = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{write_data[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = write_data;
            end
        endcase

        if (run) begin
            ram_we    = cpu_wr && hit_ram;
            ram_be    = store_be;
            ram_idx   = addr[IdxW+1:2];
            ram_wdata = store_data;
        end else begin
            ram_we    = 1'b1;
            ram_be    = 4'b1111;
            ram_idx   = clr_cnt_q;
            ram_wdata = 32'd0;
        end
        ram_re = cpu_rd && hit_ram && !req_mis;

        ld_src_d  = ld_src_q;
        ld_off_d  = ld_off_q;
        ld_mask_d = ld_mask_q;
        led_cap_d = led_cap_q;
        if (cpu_rd) begin
            ld_off_d  = addr[1:0];
            ld_mask_d = sign_mask;
            led_cap_d = led_q;
            if (req_mis) begin
                ld_src_d = SrcZero;
            end else if (hit_led) begin
                ld_src_d = SrcLed;
            end else if (hit_ram) begin
                ld_src_d = SrcRam;
            end else begin
                ld_src_d = SrcZero;
            end
        end

        led_d        = (cpu_wr && hit_led) ? write_data[7:0] : led_q;
        misaligned_d = misaligned_q || (run && (memread || memwrite) && req_mis);
    end

    // Control and CPU-visible state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            init_done_q  <= 1'b0;
            misaligned_q <= 1'b0;
            led_q        <= 8'd0;
            ld_src_q     <= SrcZero;
            ld_off_q     <= 2'd0;
            ld_mask_q    <= 4'd0;
            led_cap_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            init_done_q  <= state_q == StRun;
            misaligned_q <= misaligned_d;
            led_q        <= led_d;
            ld_src_q     <= ld_src_d;
            ld_off_q     <= ld_off_d;
            ld_mask_q    <= ld_mask_d;
            led_cap_q    <= led_cap_d;
        end
    end

    // Single-port RAM with byte-write enables; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= mem[ram_idx];
        end
    end

    load_align u_load_align (
        .word      (ram_rdata_q),
        .offset    (ld_off_q),
        .sign_mask (ld_mask_q),
        .value     (ram_load_val)
    );

    // Present the captured load result.
    always_comb begin
        case (ld_src_q)
            SrcRam:  read_data = ram_load_val;
            SrcLed:  read_data = {24'd0, led_cap_q};
            default: read_data = 32'd0;
        endcase
    end

    assign init_done  = init_done_q;
    assign misaligned = misaligned_q;
    assign led        = led_q;

endmodule
